softusb_navre_simctl: RTL and testbench

Synthesisable simulation-control and IO responder for the softusb_navre core's IO bus, replacing ad-hoc bench logic. Answers IO reads with a fixed response map and a bank of scratch registers, and detects end-of-test through a magic exit write. Enforces a cycle-limit watchdog and records every IO write in a trace FIFO that a host or bench drains. Sits beside the navre core in a regression harness or on-FPGA self-test build.

---
 rtl/softusb_navre_simctl.sv | 138 +++++++++++++
 tb/tb_softusb_navre_simctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/softusb_navre_simctl.sv
// Simulation-control and IO responder for the softusb_navre IO bus: fixed read map,
// scratch registers, exit detection, cycle watchdog and an IO-write trace FIFO.
module softusb_navre_simctl #(
  parameter int unsigned      IO_AW        = 6,
  parameter logic [IO_AW-1:0] SCRATCH_BASE = 6'h20,
  parameter int unsigned      SCRATCH_N    = 4,
  parameter logic [IO_AW-1:0] STAT_A0      = 6'h11,
  parameter logic [IO_AW-1:0] STAT_A1      = 6'h12,
  parameter logic [IO_AW-1:0] EXIT_ADDR    = 6'h00,
  parameter logic [7:0]       EXIT_CODE    = 8'hfe,
  parameter int unsigned      CYCLE_LIMIT  = 1000,
  parameter int unsigned      TRACE_DEPTH  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             io_re,
  input  logic             io_we,
  input  logic [IO_AW-1:0] io_a,
  input  logic [7:0]       io_do,
  output logic [7:0]       io_di,
  input  logic             trace_pop,
  output logic             trace_valid,
  output logic [IO_AW-1:0] trace_addr,
  output logic [7:0]       trace_data,
  output logic             trace_overflow,
  output logic             done,
  output logic             pass,
  output logic [7:0]       exit_data,
  output logic             timeout,
  output logic [31:0]      cycles
);

  localparam int unsigned PW = $clog2(TRACE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = IO_AW + 8;

  typedef enum logic [1:0] {StRun, StDone, StTimeout} state_e;

  state_e      state_q;
  logic [31:0] cycles_q;
  logic        pass_q;
  logic [7:0]  exit_data_q;
  logic [7:0]  io_di_q;
  logic [7:0]  scratch_q [SCRATCH_N];
  logic [7:0]  rd_data;

  logic          run, exit_wr, limit_hit;
  logic [EW-1:0] trace_mem_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop, full, push_ok;
  logic [EW-1:0] head;

  assign run       = (state_q == StRun);
  assign exit_wr   = run && io_we && (io_a == EXIT_ADDR);
  // Compare against the post-increment count so the limit lands on edge CYCLE_LIMIT-1.
  assign limit_hit = ((cycles_q + 32'd1) == (CYCLE_LIMIT - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StRun;
      cycles_q    <= '0;
      pass_q      <= 1'b0;
      exit_data_q <= '0;
    end else if (run) begin
      cycles_q <= cycles_q + 32'd1;
      if (exit_wr) begin
        state_q     <= StDone;
        pass_q      <= (io_do == EXIT_CODE);
        exit_data_q <= io_do;
      end else if (limit_hit) begin
        state_q <= StTimeout;
      end
    end
  end

  always_comb begin
    rd_data = 8'(io_a);
    for (int unsigned i = 0; i < SCRATCH_N; i++) begin
      if (io_a == SCRATCH_BASE + IO_AW'(i)) rd_data = scratch_q[i];
    end
    if (io_a == STAT_A0 || io_a == STAT_A1) rd_data = 8'hff;
  end

  // Read samples scratch before any same-edge write lands, giving the pre-write value.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      io_di_q <= '0;
      for (int unsigned i = 0; i < SCRATCH_N; i++) scratch_q[i] <= '0;
    end else begin
      if (io_re) io_di_q <= rd_data;
      for (int unsigned i = 0; i < SCRATCH_N; i++) begin
        if (run && io_we && io_a == SCRATCH_BASE + IO_AW'(i)) scratch_q[i] <= io_do;
      end
    end
  end

  assign push    = run && io_we;
  assign pop     = trace_pop && (count_q != '0);
  assign full    = (count_q == CW'(TRACE_DEPTH));
  assign push_ok = push && (!full || pop);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) trace_mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        trace_mem_q[wr_ptr_q] <= {io_a, io_do};
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign head           = trace_mem_q[rd_ptr_q];
  assign trace_valid    = (count_q != '0);
  assign trace_addr     = trace_valid ? head[EW-1:8] : '0;
  assign trace_data     = trace_valid ? head[7:0] : '0;
  assign trace_overflow = overflow_q;
  assign io_di          = io_di_q;
  assign done           = (state_q == StDone);
  assign timeout        = (state_q == StTimeout);
  assign pass           = pass_q;
  assign exit_data      = exit_data_q;
  assign cycles         = cycles_q;

endmodule

// File: tb/tb_softusb_navre_simctl.sv
// Directed self-checking bench for softusb_navre_simctl (TRACE_DEPTH=4, CYCLE_LIMIT=1000).
module tb_softusb_navre_simctl;

  logic        sys_clk, sys_rst;
  logic        io_re, io_we, trace_pop;
  logic [5:0]  io_a;
  logic [7:0]  io_do, io_di;
  logic        trace_valid, trace_overflow, done, pass, timeout;
  logic [5:0]  trace_addr;
  logic [7:0]  trace_data, exit_data;
  logic [31:0] cycles;

  int n_checks = 0;
  int n_errors = 0;

  softusb_navre_simctl #(
    .CYCLE_LIMIT (1000),
    .TRACE_DEPTH (4)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .io_re          (io_re),
    .io_we          (io_we),
    .io_a           (io_a),
    .io_do          (io_do),
    .io_di          (io_di),
    .trace_pop      (trace_pop),
    .trace_valid    (trace_valid),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .done           (done),
    .pass           (pass),
    .exit_data      (exit_data),
    .timeout        (timeout),
    .cycles         (cycles)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one bus cycle from a negedge, let one posedge consume it, return idle.
  task automatic cyc(input logic re, input logic we, input logic [5:0] a,
                     input logic [7:0] d, input logic pp);
    io_re = re; io_we = we; io_a = a; io_do = d; trace_pop = pp;
    @(negedge sys_clk);
    io_re = 1'b0; io_we = 1'b0; io_a = '0; io_do = '0; trace_pop = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pop_check(input string tag, input logic [5:0] a, input logic [7:0] d);
    check({tag, "_valid"}, 32'(trace_valid), 32'd1);
    check({tag, "_entry"}, {18'd0, trace_addr, trace_data}, {18'd0, a, d});
    cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    io_re = 1'b0; io_we = 1'b0; io_a = '0; io_do = '0; trace_pop = 1'b0;
    @(negedge sys_clk);
    do_reset();

    // Reset state
    check("rst_io_di", 32'(io_di), 32'h0);
    check("rst_valid", 32'(trace_valid), 32'h0);
    check("rst_ovf", 32'(trace_overflow), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_cycles", cycles, 32'd0);

    // Fib-style run: exit write on edge 40
    wr(6'h01, 8'h05);
    wr(6'h02, 8'h07);
    idle(37);
    check("fib_cycles39", cycles, 32'd39);
    wr(6'h00, 8'hfe);
    check("fib_done", 32'(done), 32'd1);
    check("fib_pass", 32'(pass), 32'd1);
    check("fib_exit_data", 32'(exit_data), 32'hfe);
    check("fib_cycles", cycles, 32'd40);
    idle(3);
    check("fib_frozen", cycles, 32'd40);
    pop_check("fib_t0", 6'h01, 8'h05);
    pop_check("fib_t1", 6'h02, 8'h07);
    pop_check("fib_t2", 6'h00, 8'hfe);
    check("fib_empty", 32'(trace_valid), 32'd0);

    // Read map
    do_reset();
    wr(6'h21, 8'h5a);
    rd(6'h11); check("rd_stat0", 32'(io_di), 32'hff);
    rd(6'h12); check("rd_stat1", 32'(io_di), 32'hff);
    rd(6'h33); check("rd_other", 32'(io_di), 32'h33);
    rd(6'h21); check("rd_scratch", 32'(io_di), 32'h5a);
    idle(2);   check("rd_hold", 32'(io_di), 32'h5a);
    rd(6'h23); check("rd_scratch_top", 32'(io_di), 32'h00);
    rd(6'h24); check("rd_past_scratch", 32'(io_di), 32'h24);
    rd(6'h1f); check("rd_below_scratch", 32'(io_di), 32'h1f);
    cyc(1'b1, 1'b1, 6'h21, 8'h77, 1'b0);
    check("rd_prewrite", 32'(io_di), 32'h5a);
    rd(6'h21); check("rd_postwrite", 32'(io_di), 32'h77);

    // Watchdog
    do_reset();
    idle(998);
    check("wd_not_yet", 32'(timeout), 32'd0);
    check("wd_cycles998", cycles, 32'd998);
    idle(1);
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_cycles", cycles, 32'd999);
    idle(2);
    check("wd_frozen", cycles, 32'd999);
    wr(6'h00, 8'hfe);
    check("wd_no_done", 32'(done), 32'd0);
    check("wd_no_trace", 32'(trace_valid), 32'd0);
    rd(6'h11); check("wd_read_served", 32'(io_di), 32'hff);

    // Failed exit; later writes ignored
    do_reset();
    wr(6'h22, 8'h3c);
    wr(6'h00, 8'h01);
    check("fx_done", 32'(done), 32'd1);
    check("fx_pass", 32'(pass), 32'd0);
    check("fx_exit_data", 32'(exit_data), 32'h01);
    wr(6'h22, 8'h99);
    rd(6'h22); check("fx_scratch_kept", 32'(io_di), 32'h3c);
    pop_check("fx_t0", 6'h22, 8'h3c);
    pop_check("fx_t1", 6'h00, 8'h01);
    check("fx_empty", 32'(trace_valid), 32'd0);

    // FIFO overflow
    do_reset();
    cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b1);
    check("ff_pop_empty", 32'(trace_valid), 32'd0);
    for (int i = 0; i < 6; i++) wr(6'h30 + 6'(i), 8'h10 + 8'(i));
    check("ff_overflow", 32'(trace_overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ff_keep", 6'h30 + 6'(i), 8'h10 + 8'(i));
    check("ff_drained", 32'(trace_valid), 32'd0);
    check("ff_ovf_sticky", 32'(trace_overflow), 32'd1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    check("fp_ovf_clear", 32'(trace_overflow), 32'd0);
    for (int i = 0; i < 4; i++) wr(6'h30 + 6'(i), 8'h20 + 8'(i));
    check("fp_full_no_ovf", 32'(trace_overflow), 32'd0);
    cyc(1'b0, 1'b1, 6'h34, 8'h24, 1'b1);
    check("fp_pp_no_ovf", 32'(trace_overflow), 32'd0);
    for (int i = 1; i < 5; i++) pop_check("fp_order", 6'h30 + 6'(i), 8'h20 + 8'(i));
    check("fp_drained", 32'(trace_valid), 32'd0);

    // Async reset mid-run
    do_reset();
    wr(6'h21, 8'h11);
    wr(6'h31, 8'h22);
    rd(6'h11);
    wr(6'h32, 8'h33);
    idle(16);
    check("ar_cycles20", cycles, 32'd20);
    check("ar_valid_pre", 32'(trace_valid), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("ar_cycles", cycles, 32'd0);
    check("ar_valid", 32'(trace_valid), 32'd0);
    check("ar_io_di", 32'(io_di), 32'd0);
    check("ar_head", {24'd0, 2'b00, trace_addr}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    idle(5);
    check("ar_restart", cycles, 32'd5);
    rd(6'h21); check("ar_scratch_clr", 32'(io_di), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
